imem_boot_loader: RTL and testbench

//  Boot/program-load controller for the RV32I core's instruction memory (256 x 32b word array).

---
 rtl/imem_pkg.sv | 8 +
 rtl/imem_word_packer.sv | 29 ++
 rtl/imem_boot_loader.sv | 127 ++++++++++++
 tb/tb_imem_boot_loader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} ldr_state_e;

    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_word_packer.sv
// Packs four accepted stream bytes into a little-endian 32-bit word.
module imem_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_cnt;
    logic [31:0] shreg;

    // Bytes shift in from the top so the first byte of a word lands in [7:0].
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {byte_in, shreg[31:8]};
        end
    end

    assign word_valid = accept && (byte_cnt == 2'd3);
    assign word       = shreg;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: packs a byte stream into instruction memory, then hands the read port to the core.
//
// state | meaning
// IDLE  | waiting for a load or run request, core held on NOP
// LOAD  | accepting stream bytes into the packer
// WRITE | single-cycle write of the packed word
// RUN   | core fetches directly from memory
module imem_boot_loader
    import imem_pkg::*;
#(
    parameter int WORD_CNT = 256,
    parameter int IDX_W    = $clog2(WORD_CNT),
    parameter int TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start,
    input  logic [IDX_W:0]   load_len,
    input  logic             run_start,
    input  logic             load_abort,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [31:0]      cpu_fetch_addr,
    output logic [31:0]      cpu_instr,
    output logic             cpu_hold,
    output logic [IDX_W-1:0] mem_raddr,
    input  logic [31:0]      mem_rdata,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_waddr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]   LEN_MAX    = (IDX_W + 1)'(WORD_CNT);

    ldr_state_e       state, state_nxt;
    logic [IDX_W-1:0] word_idx, len_m1;
    logic [TMO_W-1:0] tmo_cnt;
    logic             len_ok, start_ok, accept, word_valid, last_word, tmo_hit, pk_clear;
    logic             req_state;
    logic [31:0]      pk_word;
    logic             unused_fetch_bits;

    assign len_ok    = (load_len != '0) && (load_len <= LEN_MAX);
    assign start_ok  = load_start && len_ok;
    assign accept    = rx_valid && rx_ready;
    assign last_word = (word_idx == len_m1);
    assign tmo_hit   = (state == LOAD) && !load_abort && !accept && (tmo_cnt == '0);
    assign pk_clear  = !busy;
    assign req_state = (state == IDLE) || (state == RUN);

    imem_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .accept     (accept),
        .byte_in    (rx_data),
        .word       (pk_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_start) state_nxt = len_ok ? LOAD : IDLE;
                else if (run_start) state_nxt = RUN;
            end
            LOAD: begin
                if (load_abort)      state_nxt = IDLE;
                else if (word_valid) state_nxt = WRITE;
                else if (tmo_hit)    state_nxt = IDLE;
            end
            WRITE:   state_nxt = last_word ? RUN : LOAD;
            RUN:     if (start_ok) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // Abort masks ready so a byte offered alongside it is never accepted.
    always_comb begin
        rx_ready  = (state == LOAD) && !load_abort;
        cpu_hold  = (state != RUN);
        busy      = (state == LOAD) || (state == WRITE);
        mem_we    = (state == WRITE);
        mem_waddr = word_idx;
        mem_wdata = pk_word;
    end

    // Timeout is a down-counter reloaded on every accepted byte; zero on an idle cycle aborts.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_idx <= '0;
            len_m1   <= '0;
            tmo_cnt  <= TMO_RELOAD;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= (state == WRITE) && last_word;
            err  <= (req_state && load_start && !len_ok) ||
                    ((state == LOAD) && (load_abort || tmo_hit));
            if (req_state && start_ok) begin
                len_m1   <= IDX_W'(load_len - 1'b1);
                word_idx <= '0;
            end else if ((state == WRITE) && !last_word) begin
                word_idx <= word_idx + 1'b1;
            end
            if ((state != LOAD) || accept) tmo_cnt <= TMO_RELOAD;
            else if (tmo_cnt != '0)        tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    assign mem_raddr         = cpu_fetch_addr[IDX_W+1:2];
    assign cpu_instr         = cpu_hold ? RV32I_NOP : mem_rdata;
    assign unused_fetch_bits = ^{cpu_fetch_addr[31:IDX_W+2], cpu_fetch_addr[1:0]};

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader with a behavioural memory image model.
module tb_imem_boot_loader;
    import imem_pkg::*;

    localparam int WORD_CNT = 256;
    localparam int IDX_W    = 8;

    logic             clk = 1'b0;
    logic             reset, load_start, run_start, load_abort, rx_valid;
    logic [IDX_W:0]   load_len;
    logic [7:0]       rx_data;
    logic             rx_ready, cpu_hold, mem_we, busy, done, err;
    logic [31:0]      cpu_fetch_addr, cpu_instr, mem_rdata, mem_wdata;
    logic [IDX_W-1:0] mem_raddr, mem_waddr;

    logic [31:0] mem     [WORD_CNT];
    logic [31:0] ref_mem [WORD_CNT];
    int passed = 0, total = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0, cyc = 0;

    imem_boot_loader dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
        .run_start(run_start), .load_abort(load_abort), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .cpu_fetch_addr(cpu_fetch_addr),
        .cpu_instr(cpu_instr), .cpu_hold(cpu_hold), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_raddr];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] = mem_wdata;
            wr_cnt++;
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        reset = 1'b1; load_start = 1'b0; run_start = 1'b0; load_abort = 1'b0;
        rx_valid = 1'b0; rx_data = '0; load_len = '0;
        tickn(2);
        reset = 1'b0;
    endtask

    task automatic start_load(input int len);
        load_len   = (IDX_W + 1)'(len);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Offers one byte and waits until the loader takes it; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 16 && !acc; i++) begin
            acc = rx_ready;
            tick();
        end
        check("byte_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 12 && !done; i++) tick();
        check("done_seen", 32'(done), 32'd1);
        check("hold_at_done", 32'(cpu_hold), 32'd0);
    endtask

    // Loads n random words from index 0; the expected image is built by plain byte arithmetic.
    task automatic do_load(input int n, input bit gaps);
        logic [31:0] w;
        int c0;
        for (int i = 0; i < n; i++) ref_mem[i] = $urandom;
        start_load(n);
        c0 = cyc;
        for (int i = 0; i < n; i++) begin
            w = ref_mem[i];
            for (int j = 0; j < 4; j++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    rx_valid = 1'b0;
                    tickn($urandom_range(1, 3));
                end
                send_byte(8'((w >> (8 * j)) & 32'hFF));
            end
        end
        rx_valid = 1'b0;
        wait_done();
        if (!gaps) check("load_cycles", 32'(cyc - c0), 32'(5 * n));
    endtask

    initial begin
        logic [7:0]  t1 [8];
        logic [31:0] w0, w1, a;
        int wr0, err0, done0;

        for (int i = 0; i < WORD_CNT; i++) begin
            mem[i]     = 32'h0BAD_0000 | 32'(i);
            ref_mem[i] = 32'h0BAD_0000 | 32'(i);
        end
        cpu_fetch_addr = 32'h0;

        // Reset state, sampled while reset is still asserted
        reset = 1'b1; load_start = 1'b0; run_start = 1'b0; load_abort = 1'b0;
        rx_valid = 1'b0; rx_data = '0; load_len = '0;
        tickn(3);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        check("rst_instr", cpu_instr, RV32I_NOP);
        reset = 1'b0;

        // Bad lengths 0 and 257
        wr0 = wr_cnt; err0 = err_cnt;
        start_load(0);
        check("len0_err", 32'(err), 32'd1);
        check("len0_idle", 32'(busy), 32'd0);
        tick();
        check("len0_pulse", 32'(err), 32'd0);
        start_load(257);
        check("len257_err", 32'(err), 32'd1);
        check("len257_idle", 32'(busy), 32'd0);
        tick();
        check("badlen_err_cnt", 32'(err_cnt - err0), 32'd2);
        check("badlen_no_we", 32'(wr_cnt - wr0), 32'd0);

        // Simultaneous load_start and run_start: load wins
        run_start = 1'b1;
        start_load(1);
        run_start = 1'b0;
        check("start_wins_busy", 32'(busy), 32'd1);
        check("start_wins_hold", 32'(cpu_hold), 32'd1);
        apply_reset();

        // run_start from IDLE runs the existing image
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        cpu_fetch_addr = 32'h0000_000C;
        #1;
        check("run_hold", 32'(cpu_hold), 32'd0);
        check("run_instr", cpu_instr, ref_mem[3]);
        apply_reset();

        // Directed two-word load
        t1 = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        ref_mem[0] = 32'h0050_0013;
        ref_mem[1] = 32'h0010_0093;
        wr0 = wr_cnt; done0 = done_cnt;
        start_load(2);
        for (int i = 0; i < 8; i++) send_byte(t1[i]);
        rx_valid = 1'b0;
        check("t1_we", 32'(mem_we), 32'd1);
        check("t1_waddr", 32'(mem_waddr), 32'd1);
        check("t1_wdata", mem_wdata, 32'h0010_0093);
        check("t1_no_early_done", 32'(done), 32'd0);
        check("t1_hold_write", 32'(cpu_hold), 32'd1);
        tick();
        check("t1_done", 32'(done), 32'd1);
        check("t1_hold_fall", 32'(cpu_hold), 32'd0);
        tick();
        check("t1_done_pulse", 32'(done_cnt - done0), 32'd1);
        check("t1_mem0", mem[0], ref_mem[0]);
        check("t1_mem1", mem[1], ref_mem[1]);
        check("t1_wr_cnt", 32'(wr_cnt - wr0), 32'd2);

        // Abort after 6 bytes of a 3-word load; the 7th byte is offered with the abort
        apply_reset();
        w0 = $urandom; w1 = $urandom;
        ref_mem[0] = w0;
        wr0 = wr_cnt; err0 = err_cnt;
        start_load(3);
        for (int j = 0; j < 4; j++) send_byte(8'((w0 >> (8 * j)) & 32'hFF));
        for (int j = 0; j < 2; j++) send_byte(8'((w1 >> (8 * j)) & 32'hFF));
        load_abort = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'((w1 >> 16) & 32'hFF);
        #1;
        check("abort_ready", 32'(rx_ready), 32'd0);
        tick();
        load_abort = 1'b0;
        rx_valid   = 1'b0;
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_err", 32'(err), 32'd1);
        tickn(2);
        check("abort_err_cnt", 32'(err_cnt - err0), 32'd1);
        check("abort_wr_cnt", 32'(wr_cnt - wr0), 32'd1);
        check("abort_mem0", mem[0], w0);
        do_load(1, 1'b0);
        check("after_abort_mem0", mem[0], ref_mem[0]);

        // Stall of 1023 cycles survives; 1024 aborts
        apply_reset();
        w0 = $urandom; w1 = $urandom;
        ref_mem[0] = w0; ref_mem[1] = w1;
        err0 = err_cnt;
        start_load(2);
        for (int j = 0; j < 2; j++) send_byte(8'((w0 >> (8 * j)) & 32'hFF));
        rx_valid = 1'b0;
        tickn(1023);
        check("stall1023_busy", 32'(busy), 32'd1);
        for (int j = 2; j < 4; j++) send_byte(8'((w0 >> (8 * j)) & 32'hFF));
        for (int j = 0; j < 4; j++) send_byte(8'((w1 >> (8 * j)) & 32'hFF));
        rx_valid = 1'b0;
        wait_done();
        check("stall1023_no_err", 32'(err_cnt - err0), 32'd0);
        check("stall_mem0", mem[0], w0);
        check("stall_mem1", mem[1], w1);
        wr0 = wr_cnt;
        start_load(1);
        for (int j = 0; j < 2; j++) send_byte(8'($urandom_range(0, 255)));
        rx_valid = 1'b0;
        tickn(1023);
        check("tmo_pre_busy", 32'(busy), 32'd1);
        tick();
        check("tmo_idle", 32'(busy), 32'd0);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_hold", 32'(cpu_hold), 32'd1);
        check("tmo_no_write", 32'(wr_cnt - wr0), 32'd0);
        check("tmo_mem0_kept", mem[0], w0);

        // Full-depth load with random gaps, then randomized fetches against the model image
        apply_reset();
        do_load(WORD_CNT, 1'b1);
        cpu_fetch_addr = 32'h0000_0008;
        #1;
        check("fetch_8", cpu_instr, ref_mem[2]);
        cpu_fetch_addr = 32'h0000_0401;
        #1;
        check("fetch_wrap_raddr", 32'(mem_raddr), 32'd0);
        check("fetch_wrap_instr", cpu_instr, ref_mem[0]);
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            cpu_fetch_addr = a;
            #1;
            check("fetch_rand", cpu_instr, ref_mem[(a >> 2) % WORD_CNT]);
        end

        // run_start and load_abort are ignored in RUN
        err0 = err_cnt;
        run_start = 1'b1; load_abort = 1'b1;
        tick();
        run_start = 1'b0; load_abort = 1'b0;
        tick();
        check("run_ignore_hold", 32'(cpu_hold), 32'd0);
        check("run_ignore_err", 32'(err_cnt - err0), 32'd0);

        // Reload from RUN: hold rises on the cycle after the request
        cpu_fetch_addr = 32'h0000_0008;
        load_len   = 9'd4;
        load_start = 1'b1;
        #1;
        check("reload_req_hold", 32'(cpu_hold), 32'd0);
        tick();
        load_start = 1'b0;
        check("reload_hold", 32'(cpu_hold), 32'd1);
        check("reload_nop", cpu_instr, RV32I_NOP);
        check("reload_busy", 32'(busy), 32'd1);

        // Synchronous reset in the middle of a WRITE
        apply_reset();
        wr0 = wr_cnt;
        start_load(2);
        for (int j = 0; j < 4; j++) send_byte(8'($urandom_range(0, 255)));
        rx_valid = 1'b0;
        check("midw_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        tick();
        check("midw_we_low", 32'(mem_we), 32'd0);
        check("midw_idle", 32'(busy), 32'd0);
        check("midw_hold", 32'(cpu_hold), 32'd1);
        reset = 1'b0;
        tickn(3);
        check("midw_wr_cnt", 32'(wr_cnt - wr0), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
